// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-to-read bypass, optional
// hard-wired zero register and a one-entry-per-cycle bulk-clear sweep.
// Writes arrive from writeback; read addresses come from decode and
// are answered combinationally on every port independently.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [N_RD*DATA_W-1:0]   o_rd_data,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_clr_req,
  output logic                     o_busy,
  output logic                     o_clr_done,
  output logic                     o_wr_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_next;
  logic              r_clr_done;
  logic              r_wr_err;
  logic              w_clr_done_next;
  logic              w_wr_err_next;
  logic              w_wr_en;
  logic              w_last;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Sweep reaches its final entry; the FSM leaves CLEAR on this edge,
  // so the pointer wrapping back to zero is never observed.
  assign w_last = (r_ptr == ADDR_W'(DEPTH - 1));

  // State register: FSM state, sweep pointer and the two pulse outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_clr_done <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_clr_done <= w_clr_done_next;
      r_wr_err   <= w_wr_err_next;
    end
  end

  // Next-state logic: a clear request in IDLE starts a sweep, the last
  // entry ends it; requests arriving during a sweep are ignored.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (i_clr_req) begin
          w_state_next = S_CLEAR;
          w_ptr_next   = '0;
        end
      end
      S_CLEAR: begin
        w_ptr_next = r_ptr + ADDR_W'(1);
        if (w_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_ptr_next   = '0;
      end
    endcase
  end

  // Output logic: done pulse on the final sweep edge, error pulse for any
  // write attempted while sweeping, and the gated normal write enable.
  always_comb begin
    w_clr_done_next = 1'b0;
    w_wr_err_next   = 1'b0;
    w_wr_en         = 1'b0;
    if (r_state == S_CLEAR) begin
      w_clr_done_next = w_last;
      w_wr_err_next   = i_we;
    end else begin
      w_wr_en = i_we && !((ZERO_REG != 0) && (i_wr_addr == '0));
    end
  end

  assign o_busy     = (r_state == S_CLEAR);
  assign o_clr_done = r_clr_done;
  assign o_wr_err   = r_wr_err;

  // Storage: reset wipes every entry; the sweep zeroes one entry per
  // cycle; otherwise the write port updates the addressed entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == S_CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read ports: zero register first, then the logically-cleared array
  // during a sweep, then same-cycle forwarding, then the stored value.
  // Forwarding is suppressed under reset so every port reads zero.
  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_is_zero;
    logic              w_fwd;
    logic [DATA_W-1:0] w_rd;

    assign w_ra      = i_rd_addr[gi*ADDR_W +: ADDR_W];
    assign w_is_zero = (ZERO_REG != 0) && (w_ra == '0);
    assign w_fwd     = (BYPASS != 0) && i_rst_n && i_we && (i_wr_addr == w_ra);
    assign w_rd      = (w_is_zero || o_busy) ? '0 :
                       w_fwd                 ? i_wr_data :
                                               r_mem[w_ra];

    assign o_rd_data[gi*DATA_W +: DATA_W] = w_rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp. Instance d0 uses the default
// configuration and is compared against a behavioural model; instance
// d1 (4 read ports, 8 entries, no bypass, ordinary r0) is checked with
// directed constants.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance d0: DATA_W=32, ADDR_W=5, N_RD=2, BYPASS=1, ZERO_REG=1
  logic [9:0]   ra0;
  logic [63:0]  rd0;
  logic         we0;
  logic [4:0]   wa0;
  logic [31:0]  wd0;
  logic         clr0, busy0, done0, err0;

  // Instance d1: DATA_W=32, ADDR_W=3, N_RD=4, BYPASS=0, ZERO_REG=0
  logic [11:0]  ra1;
  logic [127:0] rd1;
  logic         we1;
  logic [2:0]   wa1;
  logic [31:0]  wd1;
  logic         clr1, busy1, done1, err1;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .BYPASS(1), .ZERO_REG(1)) d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(ra0), .o_rd_data(rd0),
    .i_we(we0), .i_wr_addr(wa0), .i_wr_data(wd0), .i_clr_req(clr0),
    .o_busy(busy0), .o_clr_done(done0), .o_wr_err(err0)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(3), .N_RD(4), .BYPASS(0), .ZERO_REG(0)) d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(ra1), .o_rd_data(rd1),
    .i_we(we1), .i_wr_addr(wa1), .i_wr_data(wd1), .i_clr_req(clr1),
    .o_busy(busy1), .o_clr_done(done1), .o_wr_err(err1)
  );

  // Reference model for d0: register contents plus the number of sweep
  // cycles still to run (0 means not sweeping).
  logic [31:0] m [32];
  int          left;
  bit          exp_done;
  bit          exp_err;

  function automatic logic [31:0] exp_rd0(logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (left > 0) return 32'd0;
    if (we0 && wa0 == a) return wd0;
    return m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    left     = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic step0();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (left > 0) begin
      m[32 - left] = 32'd0;
      exp_err = we0;
      left--;
      if (left == 0) exp_done = 1'b1;
    end else begin
      if (we0 && wa0 != 5'd0) m[wa0] = wd0;
      if (clr0) left = 32;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    step0();
    @(negedge clk);
  endtask

  task automatic drive0(bit we, logic [4:0] wa, logic [31:0] wd, bit clr,
                        logic [4:0] a0, logic [4:0] a1);
    we0 = we; wa0 = wa; wd0 = wd; clr0 = clr; ra0 = {a1, a0};
    #1;
    $display("t=%0t d0 we=%0b wa=%0d wd=%h clr=%0b ra=%0d/%0d rd=%h/%h busy=%0b",
             $time, we, wa, wd, clr, a0, a1, rd0[31:0], rd0[63:32], busy0);
  endtask

  task automatic drive1(bit we, logic [2:0] wa, logic [31:0] wd, bit clr, logic [11:0] ra);
    we1 = we; wa1 = wa; wd1 = wd; clr1 = clr; ra1 = ra;
    #1;
    $display("t=%0t d1 we=%0b wa=%0d wd=%h clr=%0b ra=%h rd0=%h busy=%0b",
             $time, we, wa, wd, clr, ra, rd1[31:0], busy1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    we0 = 0; wa0 = 0; wd0 = 0; clr0 = 0; ra0 = 0;
    we1 = 0; wa1 = 0; wd1 = 0; clr1 = 0; ra1 = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks += 5;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", busy0); end
    if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done0: got %b want 0", done0); end
    if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0: got %b want 0", err0); end
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    if (rd1 !== 128'd0) begin errors++; $display("FAIL reset_rd1: got %h want 0", rd1); end
    @(negedge clk);
    // Traffic, then reset asserted in the middle of a cycle.
    drive0(1, 5, 32'h1111, 0, 5, 9);
    drive1(1, 3, 32'h33, 0, 12'd3);
    tick();
    drive0(1, 9, 32'h2222, 0, 5, 9);
    drive1(0, 0, 0, 0, 12'd3);
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (rd0 !== 64'd0) begin errors++; $display("FAIL reset_mid_rd0: got %h want 0", rd0); end
    if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_mid_busy0: got %b want 0", busy0); end
    if (rd1[31:0] !== 32'd0) begin errors++; $display("FAIL reset_mid_rd1: got %h want 0", rd1[31:0]); end
    @(negedge clk);
    drive0(1, 5, 32'hDEADBEEF, 0, 5, 5);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive0(0, 0, 0, 0, 5, 9);
    checks += 1;
    if (rd0 !== 64'd0) begin errors++; $display("FAIL reset_hold_write: got %h want 0", rd0); end
    tick();
    drive0(1, 5, 32'hDEADBEEF, 0, 3, 3);
    tick();
    drive0(0, 0, 0, 0, 5, 0);
    checks += 2;
    if (rd0[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_r5: got %h want deadbeef", rd0[31:0]); end
    if (rd0[63:32] !== 32'd0) begin errors++; $display("FAIL reset_r0: got %h want 0", rd0[63:32]); end
    tick();
  endtask

  task automatic test_multiport();
    drive1(1, 2, 32'hA, 0, 12'd0);
    tick();
    drive1(1, 7, 32'hB, 0, 12'd0);
    tick();
    drive1(0, 0, 0, 0, {3'd0, 3'd7, 3'd2, 3'd2});
    checks += 4;
    if (rd1[31:0]   !== 32'hA) begin errors++; $display("FAIL mp_port0: got %h want a", rd1[31:0]); end
    if (rd1[63:32]  !== 32'hA) begin errors++; $display("FAIL mp_port1: got %h want a", rd1[63:32]); end
    if (rd1[95:64]  !== 32'hB) begin errors++; $display("FAIL mp_port2: got %h want b", rd1[95:64]); end
    if (rd1[127:96] !== 32'h0) begin errors++; $display("FAIL mp_port3: got %h want 0", rd1[127:96]); end
    tick();
    // 8-entry sweep
    drive1(0, 0, 0, 1, {3'd0, 3'd7, 3'd2, 3'd2});
    tick();
    begin
      int bc = 0;
      int dc = 0;
      for (int c = 0; c < 20; c++) begin
        if (busy1 === 1'b1) bc++;
        if (done1 === 1'b1) dc++;
        drive1(0, 0, 0, 0, {3'd0, 3'd7, 3'd2, 3'd2});
        tick();
      end
      checks += 2;
      if (bc != 8) begin errors++; $display("FAIL mp_sweep_len: got %0d want 8", bc); end
      if (dc != 1) begin errors++; $display("FAIL mp_sweep_done: got %0d want 1", dc); end
    end
    drive1(0, 0, 0, 0, {3'd0, 3'd7, 3'd2, 3'd2});
    checks += 1;
    if (rd1 !== 128'd0) begin errors++; $display("FAIL mp_after_sweep: got %h want 0", rd1); end
    tick();
  endtask

  task automatic test_bypass();
    drive0(1, 7, 32'h0BAD, 0, 7, 6);
    tick();
    drive0(1, 7, 32'h1234, 0, 7, 6);
    checks += 1;
    if (rd0[31:0] !== 32'h1234) begin errors++; $display("FAIL bypass_on: got %h want 1234", rd0[31:0]); end
    tick();
    drive0(0, 0, 0, 0, 7, 7);
    checks += 1;
    if (rd0 !== {32'h1234, 32'h1234}) begin errors++; $display("FAIL bypass_on_after: got %h want 1234/1234", rd0); end
    tick();
    drive1(1, 7, 32'h55, 0, 12'd7);
    tick();
    drive1(1, 7, 32'h1234, 0, 12'd7);
    checks += 1;
    if (rd1[31:0] !== 32'h55) begin errors++; $display("FAIL bypass_off_same: got %h want 55", rd1[31:0]); end
    tick();
    drive1(0, 0, 0, 0, 12'd7);
    checks += 1;
    if (rd1[31:0] !== 32'h1234) begin errors++; $display("FAIL bypass_off_after: got %h want 1234", rd1[31:0]); end
    tick();
  endtask

  task automatic test_zero_reg();
    drive0(1, 0, 32'hFFFFFFFF, 0, 0, 0);
    checks += 1;
    if (rd0 !== 64'd0) begin errors++; $display("FAIL zero_same: got %h want 0", rd0); end
    tick();
    drive0(0, 0, 0, 0, 0, 0);
    checks += 2;
    if (rd0 !== 64'd0) begin errors++; $display("FAIL zero_after: got %h want 0", rd0); end
    if (err0 !== 1'b0) begin errors++; $display("FAIL zero_wr_err: got %b want 0", err0); end
    tick();
    drive1(1, 0, 32'hFFFFFFFF, 0, 12'd0);
    tick();
    drive1(0, 0, 0, 0, 12'd0);
    checks += 1;
    if (rd1 !== {4{32'hFFFFFFFF}}) begin errors++; $display("FAIL zero_off: got %h want all ffffffff", rd1); end
    tick();
  endtask

  task automatic test_sweep();
    for (int i = 1; i < 32; i++) begin
      drive0(1, 5'(i), 32'(i), 0, 0, 0);
      tick();
    end
    drive0(0, 0, 0, 0, 17, 31);
    checks += 1;
    if (rd0 !== {32'd31, 32'd17}) begin errors++; $display("FAIL sweep_fill: got %h want 31/17", rd0); end
    tick();
    drive0(0, 0, 0, 1, 1, 2);
    tick();
    begin
      int bc = 0;
      int dc = 0;
      int ec = 0;
      for (int c = 0; c < 40; c++) begin
        bit busy_now;
        busy_now = (busy0 === 1'b1);
        if (busy_now) bc++;
        if (done0 === 1'b1) dc++;
        if (err0 === 1'b1) ec++;
        if (busy_now && bc == 10)
          drive0(1, 3, 32'h99, 0, 3, 5'($urandom_range(1, 31)));
        else
          drive0(0, 0, 0, 0, 5'($urandom_range(1, 31)), 31);
        if (busy_now) begin
          checks += 1;
          if (rd0 !== 64'd0) begin errors++; $display("FAIL sweep_read: got %h want 0", rd0); end
        end
        tick();
      end
      checks += 3;
      if (bc != 32) begin errors++; $display("FAIL sweep_len: got %0d want 32", bc); end
      if (dc != 1) begin errors++; $display("FAIL sweep_done: got %0d want 1", dc); end
      if (ec != 1) begin errors++; $display("FAIL sweep_wr_err: got %0d want 1", ec); end
    end
    drive0(0, 0, 0, 0, 3, 31);
    checks += 1;
    if (rd0 !== 64'd0) begin errors++; $display("FAIL sweep_cleared: got %h want 0", rd0); end
    tick();
  endtask

  task automatic test_abort();
    drive0(1, 6, 32'h66, 0, 6, 6);
    tick();
    drive0(0, 0, 0, 1, 6, 6);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive0(0, 0, 0, 0, 6, 6);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy0); end
    if (done0 !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done0); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    begin
      int dc = 0;
      int bc = 0;
      for (int c = 0; c < 40; c++) begin
        if (done0 === 1'b1) dc++;
        if (busy0 === 1'b1) bc++;
        drive0(0, 0, 0, 0, 6, 6);
        tick();
      end
      checks += 2;
      if (dc != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dc); end
      if (bc != 0) begin errors++; $display("FAIL abort_idle: got %0d want 0", bc); end
    end
    drive0(1, 4, 32'hCAFE, 0, 4, 6);
    tick();
    drive0(0, 0, 0, 0, 4, 6);
    checks += 1;
    if (rd0 !== {32'h0, 32'hCAFE}) begin errors++; $display("FAIL abort_write: got %h want 0/cafe", rd0); end
    tick();
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 400; c++) begin
      bit          we, clr;
      logic [4:0]  wa, a0, a1;
      logic [31:0] wd;
      checks += 3;
      if (busy0 !== (left > 0)) begin errors++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy0, (left > 0)); end
      if (done0 !== exp_done) begin errors++; $display("FAIL rnd_done c=%0d: got %b want %b", c, done0, exp_done); end
      if (err0 !== exp_err) begin errors++; $display("FAIL rnd_wr_err c=%0d: got %b want %b", c, err0, exp_err); end
      if ($urandom_range(0, 149) == 0) hold = 40;
      we  = $urandom_range(0, 1) == 1;
      wa  = 5'($urandom);
      wd  = $urandom;
      clr = ($urandom_range(0, 39) == 0) || (hold > 0);
      if (hold > 0) hold--;
      a0  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      a1  = 5'($urandom);
      drive0(we, wa, wd, clr, a0, a1);
      checks += 2;
      if (rd0[31:0] !== exp_rd0(a0)) begin errors++; $display("FAIL rnd_rd0 c=%0d: got %h want %h", c, rd0[31:0], exp_rd0(a0)); end
      if (rd0[63:32] !== exp_rd0(a1)) begin errors++; $display("FAIL rnd_rd1 c=%0d: got %h want %h", c, rd0[63:32], exp_rd0(a1)); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_multiport();
    test_bypass();
    test_zero_reg();
    test_sweep();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
